// File: rtl/keccak_pkg.sv
// Shared types and constants for the keccak byte feeder: state encoding,
// word geometry and the MSB-first byte placement helper.
package keccak_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_NUM_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KRST,
        ST_FILL,
        ST_TAIL,
        ST_WAIT
    } feeder_state_e;

    // Byte k of a word lands in bits [31-8k -: 8], so the first byte is the MSB.
    function automatic logic [WORD_W-1:0] place_byte(
        input logic [WORD_W-1:0]     word,
        input logic [BYTE_NUM_W-1:0] pos,
        input logic [7:0]            b
    );
        logic [WORD_W-1:0] w;
        w = word;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (pos == i[BYTE_NUM_W-1:0]) begin
                w[WORD_W-1-8*i -: 8] = b;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/keccak_byte_feeder.sv
// Packs a byte stream MSB-first into 32-bit words for the keccak core's word
// input, emitting the final partial/tail word and sequencing per-message resets.
module keccak_byte_feeder
    import keccak_pkg::*;
#(
    parameter int PULSE_KRESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  k_reset,
    output logic [WORD_W-1:0]     k_in,
    output logic                  k_in_ready,
    output logic                  k_is_last,
    output logic [BYTE_NUM_W-1:0] k_byte_num,
    input  logic                  k_buffer_full,
    input  logic                  k_out_ready,
    output logic                  busy
);

    feeder_state_e         state_q, state_d;
    logic [WORD_W-1:0]     acc_q, acc_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  acc_last_q, acc_last_d;
    logic                  msg_done_q, msg_done_d;
    logic [WORD_W-1:0]     out_word_q, out_word_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [BYTE_NUM_W-1:0] out_bnum_q, out_bnum_d;
    logic                  out_tail_q, out_tail_d;

    logic present;
    logic xfer;
    logic acc_full;
    logic acc_complete;
    logic move;
    logic can_take;
    logic accept;

    always_comb begin
        present      = out_valid_q && (state_q == ST_FILL || state_q == ST_TAIL);
        xfer         = present && !k_buffer_full;
        acc_full     = (cnt_q == 3'(BYTES_PER_WORD));
        acc_complete = acc_full || acc_last_q;
        move         = acc_complete && (!out_valid_q || xfer);

        // Once the last byte is in, nothing more is taken until the digest is read.
        can_take = 1'b0;
        case (state_q)
            ST_IDLE: can_take = 1'b1;
            ST_KRST,
            ST_FILL: can_take = !msg_done_q && (!acc_full || move);
            default: can_take = 1'b0;
        endcase
        accept = byte_valid && can_take;
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_last_d = acc_last_q;
        msg_done_d = msg_done_q;

        if (move) begin
            acc_d      = '0;
            cnt_d      = 3'd0;
            acc_last_d = 1'b0;
        end
        if (accept) begin
            acc_d      = place_byte(acc_d, cnt_d[BYTE_NUM_W-1:0], byte_in);
            cnt_d      = cnt_d + 3'd1;
            acc_last_d = byte_last;
            if (byte_last) begin
                msg_done_d = 1'b1;
            end
        end
        if (state_q == ST_WAIT && k_out_ready) begin
            msg_done_d = 1'b0;
        end
    end

    always_comb begin
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_bnum_d  = out_bnum_q;
        out_tail_d  = out_tail_q;

        if (xfer) begin
            out_word_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_bnum_d  = '0;
            out_tail_d  = 1'b0;
            // A full final word is followed by an all-zero word carrying is_last.
            if (out_tail_q) begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
            end
        end
        if (move) begin
            out_word_d  = acc_q;
            out_valid_d = 1'b1;
            out_last_d  = acc_last_q && !acc_full;
            out_bnum_d  = cnt_q[BYTE_NUM_W-1:0];
            out_tail_d  = acc_last_q && acc_full;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (PULSE_KRESET != 0) ? ST_KRST : ST_FILL;
                end
            end
            ST_KRST: state_d = ST_FILL;
            ST_FILL: begin
                if (xfer && out_last_q) begin
                    state_d = ST_WAIT;
                end else if (xfer && out_tail_q) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (xfer) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (k_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= 3'd0;
            acc_last_q  <= 1'b0;
            msg_done_q  <= 1'b0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bnum_q  <= '0;
            out_tail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_last_q  <= acc_last_d;
            msg_done_q  <= msg_done_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_bnum_q  <= out_bnum_d;
            out_tail_q  <= out_tail_d;
        end
    end

    assign byte_ready = can_take;
    assign k_reset    = (PULSE_KRESET != 0) && (state_q == ST_KRST);
    assign k_in       = out_word_q;
    assign k_in_ready = present;
    assign k_is_last  = out_last_q;
    assign k_byte_num = out_bnum_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
